// File: rtl/dm_access_arbiter.sv
// Two-port round-robin arbiter in front of the single-port dm_1k data memory.
// Sub-word stores are handled as read-modify-write because dm_1k writes whole words.
module dm_access_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW/8-1:0] m0_be,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW/8-1:0] m1_be,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_err,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_dout
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            gnt;
  logic            pick;
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [BW-1:0]   be_r;
  logic [DW-1:0]   wdata_r;
  logic [DW-1:0]   merge_r;
  logic [DW-1:0]   rdata_r;
  logic            err_r;
  logic            misaligned;
  logic            be_full;
  logic            be_none;
  logic [DW-1:0]   merged;

  assign misaligned = addr_r[1:0] != 2'b00;
  assign be_full    = be_r == '1;
  assign be_none    = be_r == '0;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) pick = ~last_grant;
    else if (m1_req)      pick = 1'b1;
  end

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < BW; i++)
      merged[8*i +: 8] = be_r[i] ? wdata_r[8*i +: 8] : merge_r[8*i +: 8];
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_din   = '0;
    case (state)
      IDLE: if (m0_req || m1_req) state_nxt = ACCESS;
      ACCESS: begin
        if (misaligned || !we_r || be_none) begin
          state_nxt = RESP;
        end else if (be_full) begin
          mem_we    = 1'b1;
          mem_din   = wdata_r;
          state_nxt = RESP;
        end else begin
          state_nxt = MERGE;
        end
      end
      MERGE: begin
        mem_we    = 1'b1;
        mem_din   = merged;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      be_r       <= '0;
      wdata_r    <= '0;
      merge_r    <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt        <= pick;
            last_grant <= pick;
            we_r       <= pick ? m1_we    : m0_we;
            addr_r     <= pick ? m1_addr  : m0_addr;
            be_r       <= pick ? m1_be    : m0_be;
            wdata_r    <= pick ? m1_wdata : m0_wdata;
            mem_addr   <= pick ? m1_addr  : m0_addr;
            rdata_r    <= '0;
            err_r      <= 1'b0;
          end
        end
        ACCESS: begin
          if (misaligned)                    err_r   <= 1'b1;
          else if (!we_r)                    rdata_r <= mem_dout;
          else if (!be_full && !be_none)     merge_r <= mem_dout;
        end
        default: ;
      endcase
    end
  end

  assign m0_ack   = (state == RESP) && !gnt;
  assign m1_ack   = (state == RESP) &&  gnt;
  assign m0_rdata = m0_ack ? rdata_r : '0;
  assign m1_rdata = m1_ack ? rdata_r : '0;
  assign m0_err   = m0_ack && err_r;
  assign m1_err   = m1_ack && err_r;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter with a behavioural dm_1k word memory.
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [9:0]  m0_addr = '0;
  logic [3:0]  m0_be = '0;
  logic [31:0] m0_wdata = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [9:0]  m1_addr = '0;
  logic [3:0]  m1_be = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_we;

  logic [31:0] mem [256];
  int checks = 0;
  int failures = 0;
  int ord [8];
  int nack;

  always #5 clk = ~clk;

  dm_access_arbiter #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_din;

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [9:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
    if (p == 0) begin m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wd; m0_req = 1'b1; end
    else        begin m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wd; m1_req = 1'b1; end
  endtask

  // One transaction on port p; lat counts rising edges from req launch to the ack cycle.
  task automatic do_txn(input int p, input logic we, input logic [9:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int wes);
    bit done = 1'b0;
    rd = '0; er = 1'b0; lat = 0; wes = 0;
    @(posedge clk); #1;
    set_port(p, we, addr, be, wd);
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (mem_we) wes++;
      if ((p == 0) ? m0_ack : m1_ack) begin
        done = 1'b1;
        rd = (p == 0) ? m0_rdata : m1_rdata;
        er = (p == 0) ? m0_err : m1_err;
        checks++;
        if (((p == 0) ? {m1_ack, m1_err, m1_rdata} : {m0_ack, m0_err, m0_rdata}) !== 34'd0) begin
          failures++; $display("FAIL other_port_quiet: port %0d ack seen with other port outputs nonzero, expected all 0", p);
        end
      end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL ack_timeout: port %0d got no ack in 20 cycles, expected ack", p); end
    @(posedge clk); #1;
    if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  // Watches acks until n are seen; relN drops reqN on the edge after its ack.
  task automatic run_seq(input bit rel0, input bit rel1, input int n);
    bit p0 = 1'b0, p1 = 1'b0;
    nack = 0;
    for (int c = 0; c < 60 && nack < n; c++) begin
      @(posedge clk); #1;
      if (p0) begin m0_req = 1'b0; p0 = 1'b0; end
      if (p1) begin m1_req = 1'b0; p1 = 1'b0; end
      @(negedge clk);
      if (m0_ack)      begin ord[nack] = 0; nack++; p0 = rel0; end
      else if (m1_ack) begin ord[nack] = 1; nack++; p1 = rel1; end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    checks++;
    if (nack != n) begin failures++; $display("FAIL seq_timeout: got %0d acks, expected %0d", nack, n); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m0_ack, m1_ack, m0_err, m1_err, mem_we} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 00000", {m0_ack, m1_ack, m0_err, m1_err, mem_we});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'd0) begin
      failures++; $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata});
    end
    checks++;
    if (mem_addr !== 10'd0 || mem_din !== 32'd0) begin
      failures++; $display("FAIL reset_mem_bus: got addr %h din %h expected 0 0", mem_addr, mem_din);
    end
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd; logic er; int lat, wes;
    do_txn(0, 1'b1, 10'h010, 4'b1111, 32'h11223344, rd, er, lat, wes);
    checks++;
    if (wes !== 1 || lat !== 2 || er !== 1'b0) begin
      failures++; $display("FAIL full_write: got wes %0d lat %0d err %b expected 1 2 0", wes, lat, er);
    end
    do_txn(0, 1'b0, 10'h010, 4'b0000, 32'h0, rd, er, lat, wes);
    checks++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      failures++; $display("FAIL full_read: got %h err %b expected 11223344 0", rd, er);
    end
    checks++;
    if (wes !== 0 || lat !== 2) begin
      failures++; $display("FAIL read_timing: got wes %0d lat %0d expected 0 2", wes, lat);
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd; logic er; int lat, wes;
    do_txn(1, 1'b1, 10'h010, 4'b0100, 32'h00AB0000, rd, er, lat, wes);
    checks++;
    if (wes !== 1 || lat !== 3 || er !== 1'b0) begin
      failures++; $display("FAIL partial_write: got wes %0d lat %0d err %b expected 1 3 0", wes, lat, er);
    end
    do_txn(1, 1'b0, 10'h010, 4'b0000, 32'h0, rd, er, lat, wes);
    checks++;
    if (rd !== 32'h11AB3344) begin
      failures++; $display("FAIL partial_readback: got %h expected 11ab3344", rd);
    end
  endtask

  task automatic test_misaligned_and_empty();
    logic [31:0] rd; logic er; int lat, wes;
    do_txn(0, 1'b1, 10'h013, 4'b1111, 32'hDEADBEEF, rd, er, lat, wes);
    checks++;
    if (er !== 1'b1 || wes !== 0 || lat !== 2) begin
      failures++; $display("FAIL misaligned: got err %b wes %0d lat %0d expected 1 0 2", er, wes, lat);
    end
    checks++;
    if (mem[4] !== 32'h11AB3344) begin
      failures++; $display("FAIL misaligned_mem: got %h expected 11ab3344", mem[4]);
    end
    do_txn(0, 1'b1, 10'h020, 4'b0000, 32'hCAFEF00D, rd, er, lat, wes);
    checks++;
    if (er !== 1'b0 || wes !== 0 || lat !== 2 || mem[8] !== 32'd0) begin
      failures++; $display("FAIL empty_write: got err %b wes %0d lat %0d mem %h expected 0 0 2 0", er, wes, lat, mem[8]);
    end
  endtask

  task automatic test_tie_and_alternate();
    do_reset();
    set_port(0, 1'b0, 10'h010, 4'b0000, 32'h0);
    set_port(1, 1'b0, 10'h010, 4'b0000, 32'h0);
    run_seq(1'b1, 1'b1, 2);
    checks++;
    if (ord[0] !== 0 || ord[1] !== 1) begin
      failures++; $display("FAIL tie_after_reset: got order %0d,%0d expected 0,1", ord[0], ord[1]);
    end
    set_port(0, 1'b0, 10'h010, 4'b0000, 32'h0);
    set_port(1, 1'b0, 10'h010, 4'b0000, 32'h0);
    run_seq(1'b0, 1'b0, 4);
    checks++;
    if (ord[0] !== 0 || ord[1] !== 1 || ord[2] !== 0 || ord[3] !== 1) begin
      failures++; $display("FAIL alternate: got order %0d,%0d,%0d,%0d expected 0,1,0,1", ord[0], ord[1], ord[2], ord[3]);
    end
  endtask

  task automatic test_reset_mid_merge();
    int bad = 0;
    @(posedge clk); #1;
    set_port(0, 1'b1, 10'h030, 4'b0001, 32'h000000FF);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b1) begin failures++; $display("FAIL merge_we: got %b expected 1", mem_we); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m0_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack || mem_we) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL reset_abort: got %0d active cycles expected 0", bad); end
    @(posedge clk); #1;
    set_port(0, 1'b0, 10'h010, 4'b0000, 32'h0);
    set_port(1, 1'b0, 10'h010, 4'b0000, 32'h0);
    run_seq(1'b1, 1'b1, 2);
    checks++;
    if (ord[0] !== 0 || ord[1] !== 1) begin
      failures++; $display("FAIL tie_after_abort: got order %0d,%0d expected 0,1", ord[0], ord[1]);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    set_port(0, 1'b0, 10'h010, 4'b0000, 32'h0);
    @(posedge clk); #1;
    set_port(1, 1'b0, 10'h010, 4'b0000, 32'h0);
    run_seq(1'b0, 1'b1, 3);
    checks++;
    if (ord[0] !== 0 || ord[1] !== 1 || ord[2] !== 0) begin
      failures++; $display("FAIL no_starvation: got order %0d,%0d,%0d expected 0,1,0", ord[0], ord[1], ord[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_misaligned_and_empty();
    test_tie_and_alternate();
    test_reset_mid_merge();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
